mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32, meaning the number of divider iteration cycles (one quotient bit per cycle).
REQ-002 SHALL have ports: clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: in_valid  in  1  EX request valid; in_ready  out  1  controller can accept.
REQ-004 SHALL have ports: op  in  4  one-hot, bit0 mul-lo, bit1 rem, bit2 mul-hi, bit3 div; is_sign  in  1  signed operation.
REQ-005 SHALL have ports: src1, src2  in  32  operands; flush  in  1  branch-flush abort.
REQ-006 SHALL have ports: mul_req_valid  out  1  Booth multiplier in_valid; mul_src1, mul_src2  out  32  latched operands; mul_sign  out  2  active-low sign, {~sign,~sign}.
REQ-007 SHALL have ports: mul_resp_valid  in  1  multiplier done; mul_hi, mul_lo  in  32  product halves.
REQ-008 SHALL have ports: out_valid  out  1  result ready; out_ready  in  1  MEM side accepts; result  out  32  selected result; busy  out  1  state != IDLE.

Function
REQ-009 SHALL implement states IDLE, MUL, DIV, FIX, HOLD; in_ready = (state == IDLE) & ~flush.
REQ-010 SHALL accept on in_valid & in_ready & (op != 0), latching op, is_sign, src1 and src2; op == 0 SHALL leave the state at IDLE; if more than one op bit is set, the lowest set bit SHALL win.
REQ-011 SHALL go IDLE->MUL for op[0] or op[2] and IDLE->DIV for op[1] or op[3].
REQ-012 SHALL drive mul_req_valid high in every MUL cycle; on mul_resp_valid it SHALL capture mul_lo (op[0]) or mul_hi (op[2]) into result and go to HOLD; out_valid SHALL rise one cycle after mul_resp_valid.
REQ-013 SHALL, in DIV on entry, take the absolute values when is_sign is set, then run DIV_CYCLES restoring iterations counted 0..DIV_CYCLES-1, then go to FIX.
REQ-014 SHALL, in FIX, negate the quotient when the signs differ and the remainder when src1 < 0 (signed ops only), select quotient (op[3]) or remainder (op[1]), and go to HOLD; out_valid SHALL be asserted DIV_CYCLES+2 cycles after the accept edge.
REQ-015 SHALL, for divide-by-zero, skip the iterations (DIV->FIX in 1 cycle) with quotient 0xFFFFFFFF and remainder src1.
REQ-016 SHALL, for signed 0x80000000 / 0xFFFFFFFF, skip the iterations with quotient 0x80000000 and remainder 0.
REQ-017 SHALL hold out_valid and result stable in HOLD until out_ready, then go to IDLE; an accept is possible at the earliest on the cycle after that.
REQ-018 SHALL, when flush is high in any state, go to IDLE on the next edge, deassert out_valid and mul_req_valid, and discard any partial result; a mul_resp_valid arriving after the abort SHALL be ignored.
REQ-019 SHALL NOT accept a new request in a cycle where flush is high, even in IDLE.
REQ-020 SHALL drive result as 0 when out_valid is low.

Reset
REQ-021 SHALL, on reset, set: state IDLE, iteration counter 0, latched operands and result 0, out_valid 0, mul_req_valid 0, busy 0, in_ready 1 (after the reset cycle).
REQ-022 SHALL have reset take priority over flush and abort any in-flight operation identically to flush.

Structure
REQ-023 SHALL have the state encoding, the op bit positions (MDU_MUL_LO=0, MDU_REM=1, MDU_MUL_HI=2, MDU_DIV=3) and DIV_CYCLES default in defines.sv, shared with EXE.
REQ-024 SHALL place the restoring iteration datapath (partial remainder, quotient shift register, counter, done flag) in one sub-module div_iter; the FSM, sign fix-up, special cases and handshake SHALL stay in mdu_ctrl.

Verification
REQ-025 SHALL cover a signed div: op=4'b1000, is_sign=1, src1=-7, src2=2 -> result 0xFFFFFFFD (-3) with out_valid at accept+34.
REQ-026 SHALL cover a rem by zero: op=4'b0010, src1=0x1234, src2=0 -> result 0x1234, out_valid at accept+2.
REQ-027 SHALL cover signed overflow: op=4'b1000, is_sign=1, 0x80000000 / 0xFFFFFFFF -> result 0x80000000; same with op=4'b0010 -> result 0.
REQ-028 SHALL cover mul-hi with a stub multiplier responding after 5 cycles with hi=0xDEAD0000, lo=1 and op=4'b0100 -> result 0xDEAD0000 one cycle after the response; mul_req_valid high for exactly 5 cycles; mul_sign=2'b00 when is_sign=1.
REQ-029 SHALL cover backpressure: out_ready held low for 10 cycles in HOLD -> out_valid and result stable, in_ready low; release -> IDLE on the next edge.
REQ-030 SHALL cover a flush at iteration 10 of a div -> IDLE on the next cycle, no out_valid; a new mul accepted the following cycle completes correctly.

Source files
------------

// File: rtl/defines.sv
// Shared MDU definitions: FSM state encoding, one-hot op bit positions and
// the default divider length, imported by the MDU and by EXE.
package mdu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_HOLD = 3'd4
   } mdu_state_e;

   localparam int MDU_MUL_LO     = 0;
   localparam int MDU_REM        = 1;
   localparam int MDU_MUL_HI     = 2;
   localparam int MDU_DIV        = 3;
   localparam int DIV_CYCLES_DEF = 32;

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring unsigned divider core: one quotient bit per cycle after a start
// pulse; done flags the cycle whose edge performs the final iteration.
module div_iter
   import mdu_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        abort,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        run,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(DIV_CYCLES - 1);

   logic [31:0]   rem_q, rem_d;
   logic [31:0]   quo_q, quo_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          run_q, run_d;
   logic [32:0]   rem_shift_s;
   logic [32:0]   diff_s;

   assign done      = run_q & (cnt_q == LAST_CNT);
   assign run       = run_q;
   assign quotient  = quo_q;
   assign remainder = rem_q;

   // Next-state of the iteration datapath: trial subtract, restore on borrow.
   always_comb begin
      rem_shift_s = {rem_q, quo_q[31]};
      diff_s      = rem_shift_s - {1'b0, divisor};
      rem_d       = rem_q;
      quo_d       = quo_q;
      cnt_d       = cnt_q;
      run_d       = run_q;
      if (abort) begin
         run_d = 1'b0;
         cnt_d = '0;
      end else if (start) begin
         rem_d = 32'd0;
         quo_d = dividend;
         cnt_d = '0;
         run_d = 1'b1;
      end else if (run_q) begin
         if (!diff_s[32]) begin
            rem_d = diff_s[31:0];
            quo_d = {quo_q[30:0], 1'b1};
         end else begin
            rem_d = rem_shift_s[31:0];
            quo_d = {quo_q[30:0], 1'b0};
         end
         if (done) begin
            run_d = 1'b0;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else begin
         run_d = 1'b0;
      end
   end

   // Iteration state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         rem_q <= 32'd0;
         quo_q <= 32'd0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: accepts EX requests, drives an external multiplier or the
// internal divider, applies sign fix-up/special cases and holds the result.
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  op,
   input  logic        is_sign,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   input  logic        flush,
   output logic        mul_req_valid,
   output logic [31:0] mul_src1,
   output logic [31:0] mul_src2,
   output logic [1:0]  mul_sign,
   input  logic        mul_resp_valid,
   input  logic [31:0] mul_hi,
   input  logic [31:0] mul_lo,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        busy
);

   mdu_state_e  state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic        sign_q, sign_d;
   logic [31:0] src1_q, src1_d, src2_q, src2_d;
   logic [31:0] result_q, result_d;
   logic        out_valid_q, out_valid_d;
   logic        mul_req_valid_q, mul_req_valid_d;

   logic [3:0]  op_sel_s;
   logic        div_zero_s, div_ovf_s, neg_quo_s, neg_rem_s;
   logic [31:0] abs1_s, abs2_s, quo_s, rem_s;
   logic        div_start_s, div_run_s, div_done_s;
   logic [31:0] div_quo_s, div_rem_s;

   div_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div_iter (
      .clk       (clk),
      .reset     (reset),
      .abort     (flush),
      .start     (div_start_s),
      .dividend  (abs1_s),
      .divisor   (abs2_s),
      .run       (div_run_s),
      .done      (div_done_s),
      .quotient  (div_quo_s),
      .remainder (div_rem_s)
   );

   assign in_ready      = (state_q == ST_IDLE) & ~flush;
   assign busy          = (state_q != ST_IDLE);
   assign mul_req_valid = mul_req_valid_q;
   assign mul_src1      = src1_q;
   assign mul_src2      = src2_q;
   assign mul_sign      = {~sign_q, ~sign_q};
   assign out_valid     = out_valid_q;
   assign result        = result_q;   // cleared whenever out_valid drops

   // Operand conditioning and final quotient/remainder including special cases.
   always_comb begin
      op_sel_s   = op & (~op + 4'd1);
      div_zero_s = (src2_q == 32'd0);
      div_ovf_s  = sign_q & (src1_q == 32'h8000_0000) & (src2_q == 32'hFFFF_FFFF);
      neg_quo_s  = sign_q & (src1_q[31] ^ src2_q[31]);
      neg_rem_s  = sign_q & src1_q[31];
      abs1_s     = (sign_q & src1_q[31]) ? neg32(src1_q) : src1_q;
      abs2_s     = (sign_q & src2_q[31]) ? neg32(src2_q) : src2_q;
      if (div_zero_s) begin
         quo_s = 32'hFFFF_FFFF;
         rem_s = src1_q;
      end else if (div_ovf_s) begin
         quo_s = 32'h8000_0000;
         rem_s = 32'd0;
      end else begin
         quo_s = neg_quo_s ? neg32(div_quo_s) : div_quo_s;
         rem_s = neg_rem_s ? neg32(div_rem_s) : div_rem_s;
      end
   end

   // FSM next-state and registered-output logic; flush overrides every state.
   always_comb begin
      state_d         = state_q;
      op_d            = op_q;
      sign_d          = sign_q;
      src1_d          = src1_q;
      src2_d          = src2_q;
      result_d        = result_q;
      out_valid_d     = out_valid_q;
      mul_req_valid_d = mul_req_valid_q;
      div_start_s     = 1'b0;
      if (flush) begin
         state_d         = ST_IDLE;
         result_d        = 32'd0;
         out_valid_d     = 1'b0;
         mul_req_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid && (op != 4'd0)) begin
                  op_d   = op_sel_s;
                  sign_d = is_sign;
                  src1_d = src1;
                  src2_d = src2;
                  if (op_sel_s[MDU_MUL_LO] | op_sel_s[MDU_MUL_HI]) begin
                     state_d         = ST_MUL;
                     mul_req_valid_d = 1'b1;
                  end else if (op_sel_s[MDU_REM] | op_sel_s[MDU_DIV]) begin
                     state_d = ST_DIV;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_MUL: begin
               if (mul_resp_valid) begin
                  result_d        = ({32{op_q[MDU_MUL_LO]}} & mul_lo) |
                                    ({32{op_q[MDU_MUL_HI]}} & mul_hi);
                  out_valid_d     = 1'b1;
                  mul_req_valid_d = 1'b0;
                  state_d         = ST_HOLD;
               end else begin
                  mul_req_valid_d = 1'b1;
               end
            end
            ST_DIV: begin
               // Special cases bypass the iterations entirely.
               if (!div_run_s) begin
                  if (div_zero_s | div_ovf_s) begin
                     state_d = ST_FIX;
                  end else begin
                     div_start_s = 1'b1;
                  end
               end else if (div_done_s) begin
                  state_d = ST_FIX;
               end else begin
                  state_d = ST_DIV;
               end
            end
            ST_FIX: begin
               result_d    = ({32{op_q[MDU_DIV]}} & quo_s) |
                             ({32{op_q[MDU_REM]}} & rem_s);
               out_valid_d = 1'b1;
               state_d     = ST_HOLD;
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state_d     = ST_IDLE;
                  out_valid_d = 1'b0;
                  result_d    = 32'd0;
               end else begin
                  state_d = ST_HOLD;
               end
            end
            default: begin
               state_d         = ST_IDLE;
               result_d        = 32'd0;
               out_valid_d     = 1'b0;
               mul_req_valid_d = 1'b0;
            end
         endcase
      end
   end

   // Controller state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         op_q            <= 4'd0;
         sign_q          <= 1'b0;
         src1_q          <= 32'd0;
         src2_q          <= 32'd0;
         result_q        <= 32'd0;
         out_valid_q     <= 1'b0;
         mul_req_valid_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         op_q            <= op_d;
         sign_q          <= sign_d;
         src1_q          <= src1_d;
         src2_q          <= src2_d;
         result_q        <= result_d;
         out_valid_q     <= out_valid_d;
         mul_req_valid_q <= mul_req_valid_d;
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with a stub multiplier that answers in the
// fifth cycle of mul_req_valid (hi=0xDEAD0000, lo=1).
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  op = 4'd0;
   logic        is_sign = 1'b0;
   logic [31:0] src1 = 32'd0;
   logic [31:0] src2 = 32'd0;
   logic        flush = 1'b0;
   logic        mul_req_valid;
   logic [31:0] mul_src1, mul_src2;
   logic [1:0]  mul_sign;
   logic        mul_resp_valid;
   logic [31:0] mul_hi, mul_lo;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        busy;

   int vecs = 0;
   int errs = 0;
   logic [3:0] stub_cnt = 4'd0;

   always #5 clk = ~clk;

   mdu_ctrl #(.DIV_CYCLES(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .is_sign(is_sign), .src1(src1), .src2(src2), .flush(flush),
      .mul_req_valid(mul_req_valid), .mul_src1(mul_src1), .mul_src2(mul_src2),
      .mul_sign(mul_sign), .mul_resp_valid(mul_resp_valid), .mul_hi(mul_hi),
      .mul_lo(mul_lo), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .busy(busy)
   );

   always @(posedge clk) stub_cnt <= mul_req_valid ? stub_cnt + 4'd1 : 4'd0;
   assign mul_resp_valid = mul_req_valid && (stub_cnt == 4'd4);
   assign mul_hi = 32'hDEAD_0000;
   assign mul_lo = 32'h0000_0001;

   task automatic accept(input logic [3:0] o, input logic s, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      in_valid = 1'b1; op = o; is_sign = s; src1 = a; src2 = b;
      vecs++;
      if (in_ready !== 1'b1) begin errs++; $display("FAIL accept_ready got %b want 1", in_ready); end
      @(posedge clk);
      #1 in_valid = 1'b0; op = 4'd0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      do begin
         @(posedge clk); lat++;
         @(negedge clk);
      end while (out_valid !== 1'b1 && lat < 200);
   endtask

   task automatic release_out();
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      @(negedge clk);
      vecs++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || result !== 32'd0 || in_ready !== 1'b1) begin
         errs++;
         $display("FAIL release busy=%b ov=%b res=%h rdy=%b want 0 0 0 1", busy, out_valid, result, in_ready);
      end
   endtask

   task automatic run_div(input string name, input logic [3:0] o, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int lat;
      accept(o, s, a, b);
      wait_out(lat);
      vecs++;
      if (lat != exp_lat) begin errs++; $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat); end
      vecs++;
      if (result !== exp_res) begin errs++; $display("FAIL %s_result got %h want %h", name, result, exp_res); end
      release_out();
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      vecs++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || mul_req_valid !== 1'b0 || result !== 32'd0 ||
          in_ready !== 1'b1 || mul_src1 !== 32'd0 || mul_src2 !== 32'd0 || mul_sign !== 2'b11) begin
         errs++;
         $display("FAIL reset_state busy=%b ov=%b mrv=%b res=%h rdy=%b s1=%h s2=%h ms=%b", busy, out_valid,
                  mul_req_valid, result, in_ready, mul_src1, mul_src2, mul_sign);
      end
      // reset mid-division aborts and clears latched operands
      accept(4'b1000, 1'b0, 32'd100, 32'd7);
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      vecs++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || mul_src1 !== 32'd0 || in_ready !== 1'b1) begin
         errs++;
         $display("FAIL reset_abort busy=%b ov=%b s1=%h rdy=%b", busy, out_valid, mul_src1, in_ready);
      end
   endtask

   task automatic test_op_zero();
      @(negedge clk); in_valid = 1'b1; op = 4'd0; src1 = 32'd9; src2 = 32'd3;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      vecs++;
      if (busy !== 1'b0) begin errs++; $display("FAIL op_zero_busy got %b want 0", busy); end
   endtask

   task automatic test_divide();
      run_div("sdiv", 4'b1000, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
      run_div("srem", 4'b0010, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
      run_div("udiv", 4'b1000, 1'b0, 32'd100, 32'd7, 32'd14, 34);
      run_div("prio_rem", 4'b1010, 1'b0, 32'd100, 32'd7, 32'd2, 34);
   endtask

   task automatic test_special();
      run_div("rem_by_zero", 4'b0010, 1'b0, 32'h0000_1234, 32'd0, 32'h0000_1234, 2);
      run_div("div_by_zero", 4'b1000, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
      run_div("ovf_div", 4'b1000, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
      run_div("ovf_rem", 4'b0010, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);
   endtask

   task automatic test_mul_hi();
      int req_cnt = 0;
      int resp_idx = -1;
      int out_idx = -1;
      logic [1:0] sign_seen = 2'bxx;
      accept(4'b0100, 1'b1, 32'h0000_0011, 32'h0000_0022);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (i == 0) sign_seen = mul_sign;
         if (mul_req_valid === 1'b1) req_cnt++;
         if (mul_resp_valid === 1'b1 && resp_idx < 0) resp_idx = i;
         if (out_valid === 1'b1) begin out_idx = i; break; end
      end
      vecs++;
      if (req_cnt != 5) begin errs++; $display("FAIL mulhi_req_cycles got %0d want 5", req_cnt); end
      vecs++;
      if (out_idx != 5 || resp_idx != 4) begin
         errs++; $display("FAIL mulhi_timing got resp=%0d out=%0d want 4 5", resp_idx, out_idx);
      end
      vecs++;
      if (result !== 32'hDEAD_0000) begin errs++; $display("FAIL mulhi_result got %h want dead0000", result); end
      vecs++;
      if (sign_seen !== 2'b00 || mul_src1 !== 32'h11 || mul_src2 !== 32'h22) begin
         errs++; $display("FAIL mulhi_ops got sign=%b s1=%h s2=%h want 00 11 22", sign_seen, mul_src1, mul_src2);
      end
      release_out();
   endtask

   task automatic test_backpressure();
      int lat;
      accept(4'b0101, 1'b0, 32'd5, 32'd6);
      wait_out(lat);
      vecs++;
      if (result !== 32'd1 || lat != 5) begin
         errs++; $display("FAIL prio_mullo got res=%h lat=%0d want 00000001 5", result, lat);
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); @(negedge clk);
         vecs++;
         if (out_valid !== 1'b1 || result !== 32'd1 || in_ready !== 1'b0) begin
            errs++; $display("FAIL hold_%0d got ov=%b res=%h rdy=%b want 1 1 0", i, out_valid, result, in_ready);
         end
      end
      release_out();
   endtask

   task automatic test_flush_div();
      int lat;
      accept(4'b1000, 1'b0, 32'd100, 32'd7);
      repeat (11) @(posedge clk);
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b1; op = 4'b0100; is_sign = 1'b0; src1 = 32'd3; src2 = 32'd4;
      vecs++;
      if (in_ready !== 1'b0) begin errs++; $display("FAIL flush_ready got %b want 0", in_ready); end
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      vecs++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || mul_req_valid !== 1'b0) begin
         errs++; $display("FAIL flush_idle got busy=%b ov=%b rdy=%b mrv=%b want 0 0 1 0", busy, out_valid,
                          in_ready, mul_req_valid);
      end
      @(posedge clk); #1 in_valid = 1'b0; op = 4'd0;
      wait_out(lat);
      vecs++;
      if (lat != 5 || result !== 32'hDEAD_0000 || mul_src1 !== 32'd3 || mul_sign !== 2'b11) begin
         errs++; $display("FAIL flush_then_mul got lat=%0d res=%h s1=%h ms=%b want 5 dead0000 3 11", lat,
                          result, mul_src1, mul_sign);
      end
      release_out();
   endtask

   initial begin
      test_reset();
      test_op_zero();
      test_divide();
      test_special();
      test_mul_hi();
      test_backpressure();
      test_flush_div();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
